// File: rtl/ulbf_coeffs_pkg.sv
// ulbf_coeffs_pkg: shared widths, depths and sizing helper for the coefficient path
package ulbf_coeffs_pkg;
  localparam int COEFF_DATA_WIDTH = 64;
  localparam int COEFF_FIFO_DEPTH = 512;
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/ulbf_coeffs_fifo_mem.sv
// ulbf_coeffs_fifo_mem: simple dual-port storage, one write port, registered 1-cycle read port
module ulbf_coeffs_fifo_mem #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 512
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  // write port
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  // registered read port, holds its value when not reading
  always_ff @(posedge clk)
    if (rd_en) rd_data <= mem[rd_addr];
endmodule

// File: rtl/ulbf_coeffs_sync_fifo.sv
// ulbf_coeffs_sync_fifo: coefficient buffer FIFO with prog_full, flush and debug flags; ULBF_COEFFS_FIFO_FWFT_EN selects first-word-fall-through
module ulbf_coeffs_sync_fifo
  import ulbf_coeffs_pkg::*;
#(
  parameter int DATA_WIDTH       = COEFF_DATA_WIDTH,
  parameter int FIFO_DEPTH       = COEFF_FIFO_DEPTH,
  parameter int PROG_FULL_THRESH = 500,
  parameter int RAM_READ_LATENCY = 4
) (
  input  logic                                m_axis_clk,
  input  logic                                m_axis_rst_n,
  input  logic                                flush,
  input  logic [DATA_WIDTH-1:0]               fifo_din,
  input  logic                                fifo_wr_en,
  input  logic                                fifo_rd_en,
  output logic [DATA_WIDTH-1:0]               fifo_dout,
  output logic                                fifo_data_valid,
  output logic                                fifo_prog_full,
  output logic                                full,
  output logic                                empty,
  output logic [count_width(FIFO_DEPTH)-1:0]  wr_data_count,
  output logic                                overflow,
  output logic                                underflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = count_width(FIFO_DEPTH);

  if ((FIFO_DEPTH < 16) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
      (PROG_FULL_THRESH > FIFO_DEPTH - RAM_READ_LATENCY - 2)) begin : g_bad_cfg
    $error("ulbf_coeffs_sync_fifo: invalid FIFO_DEPTH or PROG_FULL_THRESH");
  end

  logic [PW-1:0]         wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]         cnt_nxt;
  logic [DATA_WIDTH-1:0] mem_q;
  logic                  wr_acc, rd_acc, pop, loaded;
  logic                  valid_nxt, full_nxt, empty_nxt, underflow_nxt;

  assign wr_acc = fifo_wr_en && !full && !flush;
`ifdef ULBF_COEFFS_FIFO_FWFT_EN
  // the memory read register is the prefetch stage; storage refills it whenever it is free or being consumed
  assign pop           = fifo_rd_en && fifo_data_valid && !flush;
  assign rd_acc        = (wr_ptr != rd_ptr) && (!fifo_data_valid || pop) && !flush;
  assign valid_nxt     = rd_acc || (fifo_data_valid && !pop && !flush);
  assign full_nxt      = cnt_nxt == CW'(FIFO_DEPTH);
  assign empty_nxt     = cnt_nxt == '0;
  assign underflow_nxt = fifo_rd_en && !fifo_data_valid && !flush;
`else
  assign pop           = fifo_rd_en && !empty && !flush;
  assign rd_acc        = pop;
  assign valid_nxt     = rd_acc;
  assign full_nxt      = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) && (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
  assign empty_nxt     = wr_ptr_nxt == rd_ptr_nxt;
  assign underflow_nxt = fifo_rd_en && empty && !flush;
`endif
  assign wr_ptr_nxt = flush ? '0 : wr_ptr + PW'(wr_acc);
  assign rd_ptr_nxt = flush ? '0 : rd_ptr + PW'(rd_acc);
  assign cnt_nxt    = flush ? '0 : wr_data_count + CW'(wr_acc) - CW'(pop);
  assign fifo_dout  = loaded ? mem_q : '0;

  ulbf_coeffs_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_mem (
    .clk     (m_axis_clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (fifo_din),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (mem_q)
  );

  // pointers, occupancy and all flags register the next-state values; loaded masks the unreset memory output
  always_ff @(posedge m_axis_clk or negedge m_axis_rst_n)
    if (!m_axis_rst_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      wr_data_count   <= '0;
      loaded          <= 1'b0;
      fifo_data_valid <= 1'b0;
      fifo_prog_full  <= 1'b0;
      full            <= 1'b0;
      empty           <= 1'b1;
      overflow        <= 1'b0;
      underflow       <= 1'b0;
    end else begin
      wr_ptr          <= wr_ptr_nxt;
      rd_ptr          <= rd_ptr_nxt;
      wr_data_count   <= cnt_nxt;
      loaded          <= loaded || rd_acc;
      fifo_data_valid <= valid_nxt;
      fifo_prog_full  <= cnt_nxt >= CW'(PROG_FULL_THRESH);
      full            <= full_nxt;
      empty           <= empty_nxt;
      overflow        <= fifo_wr_en && full && !flush;
      underflow       <= underflow_nxt;
    end
endmodule

// File: tb/tb_ulbf_coeffs_sync_fifo.sv
// tb_ulbf_coeffs_sync_fifo: directed and random scoreboard bench for ulbf_coeffs_sync_fifo
module tb_ulbf_coeffs_sync_fifo;
  import ulbf_coeffs_pkg::*;
  localparam int DW = 64, DEPTH = 512, THR = 500, CW = count_width(DEPTH);

  logic m_axis_clk = 1'b0, m_axis_rst_n = 1'b0, flush = 1'b0, fifo_wr_en = 1'b0, fifo_rd_en = 1'b0;
  logic [DW-1:0] fifo_din = '0, fifo_dout;
  logic fifo_data_valid, fifo_prog_full, full, empty, overflow, underflow;
  logic [CW-1:0] wr_data_count;

  int checks = 0, errors = 0;
  logic [DW-1:0] exp_q[$];
  int m_cnt = 0;
  logic [DW-1:0] m_dout = '0;
  logic m_valid = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;

  always #5 m_axis_clk = ~m_axis_clk;

  ulbf_coeffs_sync_fifo dut (
    .m_axis_clk      (m_axis_clk),
    .m_axis_rst_n    (m_axis_rst_n),
    .flush           (flush),
    .fifo_din        (fifo_din),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_rd_en      (fifo_rd_en),
    .fifo_dout       (fifo_dout),
    .fifo_data_valid (fifo_data_valid),
    .fifo_prog_full  (fifo_prog_full),
    .full            (full),
    .empty           (empty),
    .wr_data_count   (wr_data_count),
    .overflow        (overflow),
    .underflow       (underflow)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("count", wr_data_count, DW'(m_cnt));
    chk("empty", empty, m_cnt == 0);
    chk("full", full, m_cnt == DEPTH);
    chk("prog_full", fifo_prog_full, m_cnt >= THR);
    chk("data_valid", fifo_data_valid, m_valid);
    chk("dout", fifo_dout, m_dout);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_udf);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cnt = 0; m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  // present one cycle of stimulus, update the reference model, then check after the edge
  task automatic cyc(input logic wr, input logic [DW-1:0] d, input logic rd, input logic fl = 1'b0);
    logic wr_ok, rd_ok;
    fifo_wr_en = wr; fifo_din = d; fifo_rd_en = rd; flush = fl;
    wr_ok = wr && m_cnt != DEPTH && !fl;
    rd_ok = rd && m_cnt != 0 && !fl;
    m_ovf = wr && m_cnt == DEPTH && !fl;
    m_udf = rd && m_cnt == 0 && !fl;
    if (rd_ok) m_dout = exp_q.pop_front();
    if (wr_ok) exp_q.push_back(d);
    if (fl) exp_q.delete();
    m_cnt = fl ? 0 : m_cnt + int'(wr_ok) - int'(rd_ok);
    m_valid = rd_ok;
    @(posedge m_axis_clk);
    #1;
    chk_all();
    fifo_wr_en = 1'b0; fifo_rd_en = 1'b0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge m_axis_clk);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_count", wr_data_count, '0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_valid", fifo_data_valid, 1'b0);
    chk("rst_dout", fifo_dout, '0);
    @(negedge m_axis_clk);
    m_axis_rst_n = 1'b1;
    tick();
`ifdef ULBF_COEFFS_FIFO_FWFT_EN
    fifo_wr_en = 1'b1; fifo_din = 64'hABCD;
    tick();
    fifo_wr_en = 1'b0;
    chk("fwft_t1_valid", fifo_data_valid, 1'b0);
    chk("fwft_t1_count", wr_data_count, 1);
    chk("fwft_t1_empty", empty, 1'b0);
    tick();
    chk("fwft_t2_valid", fifo_data_valid, 1'b1);
    chk("fwft_t2_dout", fifo_dout, 64'hABCD);
    chk("fwft_t2_count", wr_data_count, 1);
    tick();
    chk("fwft_t3_valid", fifo_data_valid, 1'b1);
    chk("fwft_t3_dout", fifo_dout, 64'hABCD);
    fifo_rd_en = 1'b1;
    tick();
    fifo_rd_en = 1'b0;
    chk("fwft_t4_valid", fifo_data_valid, 1'b0);
    chk("fwft_t4_count", wr_data_count, 0);
    chk("fwft_t4_empty", empty, 1'b1);
    chk("fwft_t4_udf", underflow, 1'b0);
    fifo_rd_en = 1'b1;
    tick();
    fifo_rd_en = 1'b0;
    chk("fwft_udf", underflow, 1'b1);
    tick();
    chk("fwft_udf_pulse", underflow, 1'b0);
`else
    for (int i = 1; i <= 5; i++) cyc(1'b1, DW'(i), 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH + 16; i++) cyc(1'b1, {$urandom, $urandom}, 1'b0);
    cyc(1'b1, 64'hDEAD, 1'b1);
    while (m_cnt > 0) cyc(1'b0, '0, 1'b1);
    cyc(1'b1, 64'h5A5A, 1'b1);
    while (m_cnt < 300) cyc(1'b1, {$urandom, $urandom}, 1'b0);
    for (int i = 0; i < 4000; i++)
      cyc(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    while (m_cnt > 37) cyc(1'b0, '0, 1'b1);
    while (m_cnt < 37) cyc(1'b1, {$urandom, $urandom}, 1'b0);
    cyc(1'b1, 64'h1234, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b1);
    for (int i = 0; i < 20; i++) cyc(1'b1, DW'(100 + i), i > 10);
    fifo_wr_en = 1'b1; fifo_din = 64'h77;
    #3;
    m_axis_rst_n = 1'b0;
    model_reset();
    #1;
    chk_all();
    @(negedge m_axis_clk);
    fifo_wr_en = 1'b0;
    m_axis_rst_n = 1'b1;
    cyc(1'b1, 64'hC0FFEE, 1'b0);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
